// File: rtl/fsm_out_packer_pkg.sv
// Shared defaults, length-width helper and FIFO entry layout for the FSM output packer.
package fsm_pack_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DEPTH = 4;

    function automatic int unsigned len_w(input int unsigned width);
        return int'($clog2(width)) + 1;
    endfunction

    typedef struct packed {
        logic [len_w(DEF_WIDTH)-1:0] len;
        logic [DEF_WIDTH-1:0]        data;
    } fifo_entry_t;

endpackage

// File: rtl/fsm_out_packer_if.sv
// Packed-word valid/ready stream from the packer to the readback logic.
interface fsm_out_packer_if #(
    parameter int unsigned WIDTH = fsm_pack_pkg::DEF_WIDTH
);
    import fsm_pack_pkg::*;

    localparam int unsigned LW = len_w(WIDTH);

    logic             word_valid;
    logic             word_ready;
    logic [WIDTH-1:0] word_data;
    logic [LW-1:0]    word_len;

    modport master (output word_valid, output word_data, output word_len, input  word_ready);
    modport slave  (input  word_valid, input  word_data, input  word_len, output word_ready);

endinterface

// File: rtl/fsm_out_packer_fifo.sv
// DEPTH-entry register FIFO; head is read combinationally, pointers carry one extra wrap bit.
module fsm_out_fifo #(
    parameter type         entry_t = fsm_pack_pkg::fifo_entry_t,
    parameter int unsigned DEPTH   = fsm_pack_pkg::DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    output entry_t                 head,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level
);
    localparam int unsigned AW = $clog2(DEPTH);

    entry_t      mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign level   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (level == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop on the same edge frees the slot a full-FIFO push needs.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/fsm_out_packer.sv
// Packs the FSM serial output LSB-first into words, with flush, buffering and sticky overflow.
module fsm_out_packer #(
    parameter int unsigned WIDTH = fsm_pack_pkg::DEF_WIDTH,
    parameter int unsigned DEPTH = fsm_pack_pkg::DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   bit_en,
    input  logic                   bit_in,
    input  logic                   flush,
    input  logic                   clr_ovf,
    fsm_out_packer_if.master       word_if,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);
    import fsm_pack_pkg::*;

    localparam int unsigned LW = len_w(WIDTH);

    typedef struct packed {
        logic [LW-1:0]    len;
        logic [WIDTH-1:0] data;
    } entry_t;

    logic [WIDTH-1:0] shift_q, shift_n;
    logic [LW-1:0]    cnt_q, cnt_n;
    logic             push;
    entry_t           push_entry;
    entry_t           head;
    logic             empty;
    logic             full;
    logic             pop;
    logic             drop;

    // The incoming bit is appended before deciding on a push, so a flush
    // on the same edge includes it and a word completed by it is not re-flushed.
    always_comb begin
        shift_n    = shift_q;
        cnt_n      = cnt_q;
        push       = 1'b0;
        push_entry = '0;
        if (bit_en) begin
            shift_n = shift_q | (WIDTH'(bit_in) << cnt_q);
            cnt_n   = cnt_q + 1'b1;
        end
        if ((cnt_n == LW'(WIDTH)) || (flush && (cnt_n != '0))) begin
            push            = 1'b1;
            push_entry.len  = cnt_n;
            push_entry.data = shift_n;
            shift_n         = '0;
            cnt_n           = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_n;
            cnt_q   <= cnt_n;
        end
    end

    assign pop  = word_if.word_ready && !empty;
    assign drop = push && full && !pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       overflow <= 1'b0;
        else if (drop)    overflow <= 1'b1;
        else if (clr_ovf) overflow <= 1'b0;
    end

    fsm_out_fifo #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .empty     (empty),
        .full      (full),
        .level     (level)
    );

    assign word_if.word_valid = !empty;
    assign word_if.word_data  = head.data;
    assign word_if.word_len   = head.len;

endmodule

// File: tb/tb_fsm_out_packer.sv
// Randomised and directed checks of fsm_out_packer against a queue-based reference model.
module tb_fsm_out_packer;
    import fsm_pack_pkg::*;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LVW   = $clog2(DEPTH) + 1;

    logic           clk     = 1'b0;
    logic           reset   = 1'b0;
    logic           bit_en  = 1'b0;
    logic           bit_in  = 1'b0;
    logic           flush   = 1'b0;
    logic           clr_ovf = 1'b0;
    logic [LVW-1:0] level;
    logic           overflow;

    fsm_out_packer_if #(.WIDTH(WIDTH)) wif ();

    fsm_out_packer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .bit_en   (bit_en),
        .bit_in   (bit_in),
        .flush    (flush),
        .clr_ovf  (clr_ovf),
        .word_if  (wif.master),
        .level    (level),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: queue of buffered words plus the pending partial word.
    int unsigned q_data[$];
    int unsigned q_len[$];
    int unsigned part_data = 0;
    int unsigned part_cnt  = 0;
    bit          m_ovf     = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_data.delete();
        q_len.delete();
        part_data = 0;
        part_cnt  = 0;
        m_ovf     = 1'b0;
    endtask

    task automatic model_edge();
        bit          pop, was_full, do_push, drop;
        int unsigned pd, pl;
        pop      = (q_data.size() != 0) && (wif.word_ready == 1'b1);
        was_full = (q_data.size() == DEPTH);
        do_push  = 1'b0;
        drop     = 1'b0;
        pd       = 0;
        pl       = 0;
        if (bit_en) begin
            part_data = part_data | (int'(bit_in) << part_cnt);
            part_cnt++;
        end
        if (part_cnt == WIDTH || (flush && part_cnt != 0)) begin
            do_push   = 1'b1;
            pd        = part_data;
            pl        = part_cnt;
            part_data = 0;
            part_cnt  = 0;
        end
        if (pop) begin
            void'(q_data.pop_front());
            void'(q_len.pop_front());
        end
        if (do_push) begin
            if (was_full && !pop) drop = 1'b1;
            else begin
                q_data.push_back(pd);
                q_len.push_back(pl);
            end
        end
        if (drop)         m_ovf = 1'b1;
        else if (clr_ovf) m_ovf = 1'b0;
    endtask

    task automatic compare_outputs();
        bit v;
        v = (q_data.size() != 0);
        check("word_valid", 64'(wif.word_valid), 64'(v));
        if (v) begin
            check("word_data", 64'(wif.word_data), 64'(q_data[0]));
            check("word_len",  64'(wif.word_len),  64'(q_len[0]));
        end
        check("level",    64'(level),    64'(q_data.size()));
        check("overflow", 64'(overflow), 64'(m_ovf));
    endtask

    task automatic drive(input bit en, input bit b, input bit fl, input bit rdy, input bit clr);
        bit_en         = en;
        bit_in         = b;
        flush          = fl;
        wif.word_ready = rdy;
        clr_ovf        = clr;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_outputs();
    endtask

    task automatic idle(input bit rdy);
        drive(1'b0, 1'b0, 1'b0, rdy, 1'b0);
        step();
    endtask

    task automatic send_bits(input logic [31:0] value, input int n, input bit rdy);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, value[i], 1'b0, rdy, 1'b0);
            step();
        end
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        model_reset();
        #1;
        check("rst_valid",    64'(wif.word_valid), 64'(0));
        check("rst_data",     64'(wif.word_data),  64'(0));
        check("rst_len",      64'(wif.word_len),   64'(0));
        check("rst_level",    64'(level),          64'(0));
        check("rst_overflow", 64'(overflow),       64'(0));
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        wif.word_ready = 1'b0;
        model_reset();
        #1;
        check("init_valid",    64'(wif.word_valid), 64'(0));
        check("init_data",     64'(wif.word_data),  64'(0));
        check("init_len",      64'(wif.word_len),   64'(0));
        check("init_level",    64'(level),          64'(0));
        check("init_overflow", 64'(overflow),       64'(0));
        #11 reset = 1'b1;

        // One full word popped immediately.
        send_bits(32'h8D, 8, 1'b1);
        check("tp1_valid", 64'(wif.word_valid), 64'(1));
        check("tp1_data",  64'(wif.word_data),  64'(8'h8D));
        check("tp1_len",   64'(wif.word_len),   64'(8));
        idle(1'b1);
        check("tp1_gone",  64'(wif.word_valid), 64'(0));
        check("tp1_level", 64'(level),          64'(0));

        // Flush of a partial word; second flush with empty packer is a no-op.
        send_bits(32'h3, 3, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        check("tp2_data", 64'(wif.word_data), 64'(8'h03));
        check("tp2_len",  64'(wif.word_len),  64'(3));
        step();
        check("tp2_noword", 64'(level), 64'(1));
        drain();

        // Overflow with stalled reader, then ordered drain and clear.
        for (int w = 1; w <= 5; w++) send_bits(32'(w), 8, 1'b0);
        check("tp3_level", 64'(level),    64'(4));
        check("tp3_ovf",   64'(overflow), 64'(1));
        for (int w = 1; w <= 4; w++) begin
            check("tp3_order", 64'(wif.word_data), 64'(w));
            idle(1'b1);
        end
        check("tp3_empty", 64'(level), 64'(0));
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        check("tp3_clr", 64'(overflow), 64'(0));

        // Push and pop on the same edge while full.
        for (int w = 0; w < 4; w++) send_bits(32'h11 + 32'(w), 8, 1'b0);
        send_bits(32'hAA, 7, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        check("tp4_level", 64'(level),    64'(4));
        check("tp4_ovf",   64'(overflow), 64'(0));
        for (int w = 0; w < 3; w++) idle(1'b1);
        check("tp4_last", 64'(wif.word_data), 64'(8'hAA));
        drain();

        // Reset mid-word discards the partial bits.
        send_bits(32'h1B, 5, 1'b0);
        pulse_reset();
        send_bits(32'hFF, 8, 1'b0);
        check("tp5_data", 64'(wif.word_data), 64'(8'hFF));
        check("tp5_len",  64'(wif.word_len),  64'(8));
        drain();

        // Bit and flush on the same edge.
        send_bits(32'h1, 2, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        check("tp6_data", 64'(wif.word_data), 64'(8'h05));
        check("tp6_len",  64'(wif.word_len),  64'(3));
        drain();

        // Randomised traffic.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) pulse_reset();
            drive($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) < 4, $urandom_range(0, 19) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fsm_out_packer.md
Name: fsm_out_packer

Overview:
- Downstream consumer of the Mealy FSM serial output `out`.
- Samples the 1-bit stream on qualified clock edges and packs bits LSB-first into WIDTH-bit words.
- Buffers completed words in a small FIFO and presents them on a valid/ready interface to the test/readback logic.
- Provides flush of partial words and sticky overflow detection, so a stalled reader never silently corrupts captured FSM behaviour.

Parameters:
- WIDTH, 8, bits per packed word (2..32).
- DEPTH, 4, FIFO word entries; power of two, >=2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- bit_en  in  1  sample strobe; bit_in is captured on the rising edge where bit_en=1.
- bit_in  in  1  serial data; connects to FSM `out`.
- flush  in  1  single-cycle request to emit the current partial word.
- word_valid  out  1  FIFO non-empty.
- word_ready  in  1  consumer accepts the head word when word_valid=1.
- word_data  out  WIDTH  head word; bit0 = earliest sampled bit; unused high bits are 0.
- word_len  out  $clog2(WIDTH)+1  number of valid bits in word_data (1..WIDTH).
- level  out  $clog2(DEPTH)+1  FIFO occupancy (0..DEPTH).
- overflow  out  1  sticky; set when a word is dropped because the FIFO is full.
- clr_ovf  in  1  synchronous clear of overflow.

Behaviour:
- Reset is asynchronous, active-low; clock is clk. While reset=0, all of the following hold:
  - shift register = 0, bit_cnt = 0
  - FIFO pointers = 0, level = 0, word_valid = 0
  - word_data = 0, word_len = 0, overflow = 0
- Reset mid-word discards the partial word; no push occurs.
- Packing:
  - On an edge with bit_en=1, bit_in is written to position bit_cnt and bit_cnt increments.
  - When the incoming bit makes bit_cnt reach WIDTH, the completed word (including that bit) is pushed with len=WIDTH on the same edge, and bit_cnt and the shift register return to 0.
- Flush:
  - On an edge with flush=1 and bit_en=1, the bit is appended first.
  - If the resulting count is 0 or WIDTH (already pushed), there is no extra push.
  - Otherwise, the partial word is pushed zero-padded with len = count, and the packer clears.
  - Flush with an empty packer is a no-op.
- Push latency: a word completed or flushed at edge k is visible at word_data/word_valid after edge k if the FIFO was empty. Zero added cycles; the head is read combinationally from FIFO registers.
- Pop: occurs on any edge with word_valid=1 and word_ready=1. word_ready while empty is ignored.
- Full:
  - A push while level=DEPTH and no pop drops the new word and sets overflow.
  - FIFO contents and pointers are unchanged.
- Simultaneous push and pop at full: both succeed, level stays DEPTH, overflow is not set.
- Simultaneous push and pop at empty: the push succeeds and the pop does nothing. level becomes 1.
- Pointers wrap modulo DEPTH. level = wr_ptr - rd_ptr using one extra MSB.
- clr_ovf together with a new drop on the same edge: set wins, and overflow stays 1.
- No combinational path from word_ready to word_valid.

Decomposition:
- Package fsm_pack_pkg:
  - default WIDTH and DEPTH
  - function len_w(WIDTH) = $clog2(WIDTH)+1
  - typedef for the FIFO entry {len, data}
- One sub-module: fsm_out_fifo. Synchronous DEPTH-entry register FIFO with push/pop/full/empty/level and head read. The packer, flush and overflow logic stay in the top level.

Test Plan:
- Bits 1,0,1,1,0,0,0,1 on 8 consecutive bit_en cycles, word_ready=1 -> one word, data=0x8D, len=8, word_valid for exactly 1 cycle, level returns to 0.
- Bits 1,1,0 then flush=1 (bit_en=0) -> data=0x03, len=3. A following flush with no new bits produces no word.
- word_ready=0, stream 5 full words 0x01..0x05 -> level=4, overflow=1. Then drain: reads 0x01,0x02,0x03,0x04 in order; 0x05 is lost. clr_ovf -> overflow=0.
- FIFO full, 8th bit of a new word 0xAA arrives on the same edge as a pop -> level stays 4, overflow stays 0, 0xAA is the last word read.
- 5 bits sampled, then reset pulsed low for 1 cycle -> all outputs 0. The next 8 bits 0xFF yield data=0xFF, len=8 with no residue.
- bit_en=1 and flush=1 on the same edge after 2 bits (1,0), with bit_in=1 -> data=0x05, len=3.
